// File: rtl/btn_event.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_event: turns a debounced button level into press / short / long /      |
// | repeat / release pulses. Rev 1.0                                           |
// +----------------------------------------------------------------------------+
// "repeat" and "release" are reserved words in SystemVerilog, so those pulses
// are named rpt and rel.
module btn_event #(
  parameter int TICK_DIV     = 1250000,
  parameter int LONG_TICKS   = 40,
  parameter int REPEAT_TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic bin,
  input  logic rep_en,
  output logic press,
  output logic short_press,
  output logic long_press,
  output logic rpt,
  output logic rel,
  output logic held
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] c_TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] c_TICK_ONE  = TW'(1);
  localparam logic [7:0]    c_LONG_LAST = 8'(LONG_TICKS - 1);
  localparam logic [7:0]    c_REP_LAST  = 8'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    S_LOCK    = 2'd0,
    S_IDLE    = 2'd1,
    S_PRESSED = 2'd2,
    S_HELD    = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tick, w_tick_nxt;
  logic [7:0]    r_hold, w_hold_nxt;
  logic [7:0]    r_rep, w_rep_nxt;
  logic          w_press, w_short, w_long, w_rpt, w_rel, w_held;
  logic          w_tick;

  assign w_tick = (r_tick == c_TICK_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_hold_nxt  = r_hold;
    w_rep_nxt   = r_rep;
    w_press     = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_rpt       = 1'b0;
    w_rel       = 1'b0;
    case (r_state)
      S_LOCK: begin
        w_tick_nxt = '0;
        if (!bin) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        w_tick_nxt = '0;
        w_hold_nxt = '0;
        w_rep_nxt  = '0;
        if (bin) begin
          w_press     = 1'b1;
          w_state_nxt = S_PRESSED;
        end
      end
      S_PRESSED: begin
        // Release wins over a coincident tick.
        if (!bin) begin
          w_rel       = 1'b1;
          w_short     = 1'b1;
          w_state_nxt = S_IDLE;
          w_tick_nxt  = '0;
          w_hold_nxt  = '0;
          w_rep_nxt   = '0;
        end else begin
          w_tick_nxt = w_tick ? '0 : r_tick + c_TICK_ONE;
          if (w_tick) begin
            if (r_hold == c_LONG_LAST) begin
              w_long      = 1'b1;
              w_state_nxt = S_HELD;
              w_rep_nxt   = '0;
            end else begin
              w_hold_nxt = r_hold + 8'd1;
            end
          end
        end
      end
      S_HELD: begin
        if (!bin) begin
          w_rel       = 1'b1;
          w_state_nxt = S_IDLE;
          w_tick_nxt  = '0;
          w_hold_nxt  = '0;
          w_rep_nxt   = '0;
        end else begin
          w_tick_nxt = w_tick ? '0 : r_tick + c_TICK_ONE;
          // Repeat cadence keeps running even while rep_en masks the pulse.
          if (w_tick) begin
            if (r_rep == c_REP_LAST) begin
              w_rep_nxt = '0;
              w_rpt     = rep_en;
            end else begin
              w_rep_nxt = r_rep + 8'd1;
            end
          end
        end
      end
      default: w_state_nxt = S_LOCK;
    endcase
    w_held = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_HELD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LOCK;
      r_tick      <= '0;
      r_hold      <= '0;
      r_rep       <= '0;
      press       <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      rpt         <= 1'b0;
      rel         <= 1'b0;
      held        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick      <= w_tick_nxt;
      r_hold      <= w_hold_nxt;
      r_rep       <= w_rep_nxt;
      press       <= w_press;
      short_press <= w_short;
      long_press  <= w_long;
      rpt         <= w_rpt;
      rel         <= w_rel;
      held        <= w_held;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_event.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_btn_event: scoreboard bench for btn_event (TICK_DIV=4, LONG=3, REP=2).  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_btn_event;

  localparam int TICK_DIV = 4;
  localparam int LONG_T   = 3;
  localparam int REP_T    = 2;
  // Pulse vector bit order: {press, short_press, long_press, rpt, rel}
  localparam logic [4:0] c_P = 5'b10000;
  localparam logic [4:0] c_S = 5'b01000;
  localparam logic [4:0] c_L = 5'b00100;
  localparam logic [4:0] c_R = 5'b00010;
  localparam logic [4:0] c_X = 5'b00001;

  typedef struct {
    int         e;
    logic [4:0] v;
    logic       h;
  } exp_t;

  logic clk = 1'b0;
  logic rst, bin, rep_en;
  logic press, short_press, long_press, rpt, rel, held;

  exp_t       r_q[$];
  int         edge_n = 0;
  int         n_chk = 0;
  int         n_err = 0;
  logic       mon_en = 1'b0;
  logic [4:0] exp_v;
  logic       exp_held = 1'b0;
  exp_t       ent;

  btn_event #(.TICK_DIV(TICK_DIV), .LONG_TICKS(LONG_T), .REPEAT_TICKS(REP_T)) dut (
    .clk(clk), .rst(rst), .bin(bin), .rep_en(rep_en),
    .press(press), .short_press(short_press), .long_press(long_press),
    .rpt(rpt), .rel(rel), .held(held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic push(input int e, input logic [4:0] v, input logic h);
    exp_t x;
    x.e = e; x.v = v; x.h = h;
    r_q.push_back(x);
  endtask

  task automatic wait_edge(input int t);
    while (edge_n < t) @(negedge clk);
  endtask

  task automatic start_press(output int k);
    k = edge_n + 1;
    bin = 1'b1;
    push(k, c_P, 1'b1);
  endtask

  // Outputs for edge n are checked at the following negedge.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_v = 5'b0;
      if (r_q.size() > 0 && r_q[0].e == edge_n) begin
        ent      = r_q.pop_front();
        exp_v    = ent.v;
        exp_held = ent.h;
      end
      check("pulses", {3'b0, press, short_press, long_press, rpt, rel}, {3'b0, exp_v});
      check("held", {7'b0, held}, {7'b0, exp_held});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d observed=running expected=finished", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; bin = 1'b1; rep_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Stuck-high button out of reset: no events until a 0->1.
    wait_edge(edge_n + 20);
    bin = 1'b0;
    wait_edge(edge_n + 2);
    start_press(k);
    wait_edge(k + 1); bin = 1'b0; push(k + 2, c_X | c_S, 1'b0);
    wait_edge(k + 4);

    // Short press released at +8.
    start_press(k);
    wait_edge(k + 7); bin = 1'b0; push(k + 8, c_X | c_S, 1'b0);
    wait_edge(k + 10);

    // Long hold with repeats.
    start_press(k);
    push(k + 12, c_L, 1'b1); push(k + 20, c_R, 1'b1);
    push(k + 28, c_R, 1'b1); push(k + 36, c_R, 1'b1);
    wait_edge(k + 39); bin = 1'b0; push(k + 40, c_X, 1'b0);
    wait_edge(k + 42);

    // rep_en low over edges 16..24 masks one repeat, cadence unchanged.
    start_press(k);
    push(k + 12, c_L, 1'b1); push(k + 28, c_R, 1'b1); push(k + 36, c_R, 1'b1);
    wait_edge(k + 15); rep_en = 1'b0;
    wait_edge(k + 24); rep_en = 1'b1;
    wait_edge(k + 39); bin = 1'b0; push(k + 40, c_X, 1'b0);
    wait_edge(k + 42);

    // Release coinciding with the long tick.
    start_press(k);
    wait_edge(k + 11); bin = 1'b0; push(k + 12, c_X | c_S, 1'b0);
    wait_edge(k + 14);

    // Reset in HELD: silent abort, then a normal short press.
    start_press(k);
    push(k + 12, c_L, 1'b1); push(k + 20, c_R, 1'b1);
    wait_edge(k + 21); rst = 1'b1; bin = 1'b0; push(k + 22, 5'b0, 1'b0);
    wait_edge(k + 22); rst = 1'b0;
    wait_edge(k + 24);
    start_press(k);
    wait_edge(k + 7); bin = 1'b0; push(k + 8, c_X | c_S, 1'b0);
    wait_edge(k + 9);

    // Re-press right after a release.
    start_press(k);
    wait_edge(k); bin = 1'b0; push(k + 1, c_X | c_S, 1'b0);
    wait_edge(k + 1); start_press(k);
    wait_edge(k); bin = 1'b0; push(k + 1, c_X | c_S, 1'b0);
    wait_edge(k + 4);

    check("queue_empty", 8'(r_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
